bram_bit_reader: RTL and testbench
==================================

Name: bram_bit_reader

Overview:
- Downstream consumer of the 8-bit-in / 1-bit-out packing BRAM (port B: 1976 x 1, 12-bit address).
- On a start command it walks a range of bit addresses and issues port-B reads, absorbing the fixed BRAM read latency.
- It emits the bits as a valid/ready serial stream, MSB of each packed byte first, to the modulator/framer stage.
- A small credit FIFO lets the stream stall under backpressure without losing or repeating bits.

Parameters:
- DEPTH_B, 1976, number of bit addresses in port B; address wraps from DEPTH_B-1 to 0.
- ADDR_W, 12, width of the bit address.
- RD_LAT, 1, BRAM port-B read latency in clocks from o_en_rd/o_addr_rd to valid i_rd_bit (1 or 2).
- FIFO_D, RD_LAT+2, depth of the output credit FIFO.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1.
- i_base  in  ADDR_W  first bit address, sampled on i_start.
- i_length  in  ADDR_W  number of bits to emit, sampled on i_start (0..DEPTH_B).
- o_addr_rd  out  ADDR_W  BRAM port-B address.
- o_en_rd  out  1  BRAM port-B enable (one read per asserted cycle).
- i_rd_bit  in  1  BRAM port-B data, valid RD_LAT cycles after o_en_rd.
- o_bit  out  1  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready; a transfer occurs when o_valid & i_ready.
- o_last  out  1  marks the final bit of the pass, qualified by o_valid.
- o_busy  out  1  high from the cycle after an accepted i_start until o_done.
- o_done  out  1  one-cycle pulse after the final bit transfers.

Behaviour:
- Reset: all outputs 0, o_addr_rd=0, FIFO empty, in-flight count 0, FSM in IDLE. Reset is asynchronous, so it takes effect immediately, including mid-pass; any in-flight BRAM data is discarded.
- FSM IDLE:
  - i_start with i_length!=0: latch base/length, rd_cnt=length, go to RUN, o_busy=1 next cycle.
  - i_start with i_length=0: o_done pulses the next cycle; o_busy stays 0.
- FSM RUN, issue:
  - o_en_rd=1 when rd_cnt!=0 and (fifo_count + inflight) < FIFO_D.
  - Each issue presents o_addr_rd, post-increments the address (DEPTH_B-1 -> 0) and decrements rd_cnt.
- FSM RUN, capture: a RD_LAT-deep valid shift register tracks issued reads; when it pops, i_rd_bit is pushed into the FIFO together with a last flag (set when the issue had rd_cnt==1).
- FSM RUN, output:
  - o_valid = FIFO not empty; o_bit/o_last come from the FIFO head.
  - o_bit/o_last must hold stable while o_valid & !i_ready.
  - Pop on transfer.
- FSM RUN -> DRAIN: when rd_cnt reaches 0. DRAIN -> IDLE: when the last-flagged bit transfers, with o_done=1 in that following cycle and o_busy=0.
- Throughput: 1 bit/clock sustained with i_ready held high. First o_valid appears RD_LAT+1 clocks after i_start.
- The credit rule guarantees the FIFO never overflows: a push never occurs on a full FIFO, even when push and pop are simultaneous.
- i_start while busy: ignored, and no latch changes.

Optional Feature:
- Macro BIT_READER_LOOP_EN.
- Defined:
  - Adds input i_stop (1 bit).
  - At the end of each pass the issue logic reloads the address from the latched base and rd_cnt from the latched length, with no bubble, so the frame repeats continuously. o_last marks the last bit of every pass.
  - i_stop (sticky until the pass ends) lets the current pass finish, then behaves as non-loop: DRAIN, then o_done.
- Not defined: single pass only; no i_stop port.

Test Plan:
- Port-B model preloaded so that bits 0..31 = CF 80 AA 31 MSB-first, RD_LAT=1; start base=0 length=32, i_ready=1:
  - Stream must be 11001111 10000000 10101010 00110001.
  - o_last on bit 32; o_done one cycle later.
  - First o_valid 2 clocks after i_start.
- Same preload, i_ready pseudo-random 50%: identical 32-bit sequence; o_bit stable during every stall; o_en_rd never issued while the FIFO plus in-flight reads total FIFO_D.
- Wrap case: base=1972, length=8 with addresses 1972..1975 and 0..3 preloaded. o_addr_rd sequence must be 1972,1973,1974,1975,0,1,2,3 and the 8 bits must match.
- i_length=0 gives an o_done pulse 1 cycle after i_start with no o_en_rd. A second i_start during RUN is ignored and the stream is unchanged.
- Reset asserted after 10 of 32 bits: outputs 0 immediately. A new start base=0 length=4 then yields 1100 cleanly.
- LOOP_EN: base=0 length=8 (0xF3), i_stop raised mid-third pass. Output is 11110011 x3, o_last 3 times, o_done once, and no gap cycles between passes.

Source files
------------

// File: rtl/bram_bit_reader_if.sv
// bram_bit_reader_if: start/status, BRAM port-B read and serial stream signals of bram_bit_reader.
// Optional feature macro: BIT_READER_LOOP_EN adds the i_stop input for continuous frame looping.
interface bram_bit_reader_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W-1:0] i_length;
  logic [ADDR_W-1:0] o_addr_rd;
  logic              o_en_rd;
  logic              i_rd_bit;
  logic              o_bit;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
`ifdef BIT_READER_LOOP_EN
  logic              i_stop;
`endif

  // Reader side: consumes commands/BRAM data, drives BRAM address and the stream.
  modport master (
    input  i_start, i_base, i_length, i_rd_bit, i_ready,
`ifdef BIT_READER_LOOP_EN
    input  i_stop,
`endif
    output o_addr_rd, o_en_rd, o_bit, o_valid, o_last, o_busy, o_done
  );

  // Environment side: controller, BRAM port B and stream sink.
  modport slave (
    output i_start, i_base, i_length, i_rd_bit, i_ready,
`ifdef BIT_READER_LOOP_EN
    output i_stop,
`endif
    input  o_addr_rd, o_en_rd, o_bit, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/bram_bit_reader.sv
// bram_bit_reader: walks a range of bit addresses in the 1-bit-wide BRAM port B and emits the bits
// as a valid/ready serial stream. Reads are credit-limited so the small output FIFO never
// overflows under backpressure. Optional macro BIT_READER_LOOP_EN repeats the frame until i_stop.
module bram_bit_reader #(
  parameter int unsigned DEPTH_B = 1976,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned FIFO_D  = RD_LAT + 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  bram_bit_reader_if.master bus
);

  localparam int unsigned PtrW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int unsigned CntW = $clog2(FIFO_D + 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH_B - 1);
  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(FIFO_D - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0] last_sr_q, last_sr_d;
  logic              done_q, done_d;

  logic              fifo_bit_q  [FIFO_D];
  logic              fifo_last_q [FIFO_D];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;

  logic              is_idle, start_acc, start_zero;
  logic [ADDR_W-1:0] issue_cnt, issue_addr, reload_base, reload_len;
  logic              credit_ok, issue, issue_last, reload;
  logic              push, pop, fifo_nempty, drain_end;
  int unsigned       inflight;

`ifdef BIT_READER_LOOP_EN
  logic stop_q, stop_d;
`endif

  // Count reads issued to the BRAM whose data has not yet been captured.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight += 32'(vld_sr_q[i]);
    end
  end

  // Issue, capture and stream-handshake decisions plus datapath next-state.
  always_comb begin
    is_idle     = (state_q == StIdle);
    start_acc   = is_idle && bus.i_start && (bus.i_length != '0);
    start_zero  = is_idle && bus.i_start && (bus.i_length == '0);
    // The first read goes out in the start cycle itself to meet the RD_LAT+1 first-valid latency.
    issue_cnt   = is_idle ? bus.i_length : rd_cnt_q;
    issue_addr  = is_idle ? bus.i_base : addr_q;
    reload_base = is_idle ? bus.i_base : base_q;
    reload_len  = is_idle ? bus.i_length : len_q;
    credit_ok   = (32'(fifo_cnt_q) + inflight) < FIFO_D;
    issue       = credit_ok && (start_acc || ((state_q == StRun) && (rd_cnt_q != '0)));
    issue_last  = (issue_cnt == ADDR_W'(1));
`ifdef BIT_READER_LOOP_EN
    reload      = !(stop_q || bus.i_stop);
`else
    reload      = 1'b0;
`endif

    base_d   = start_acc ? bus.i_base : base_q;
    len_d    = start_acc ? bus.i_length : len_q;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    if (issue) begin
      if (issue_last && reload) begin
        addr_d   = reload_base;
        rd_cnt_d = reload_len;
      end else begin
        addr_d   = (issue_addr == AddrLast) ? '0 : issue_addr + ADDR_W'(1);
        rd_cnt_d = issue_cnt - ADDR_W'(1);
      end
    end

    vld_sr_d     = vld_sr_q;
    last_sr_d    = last_sr_q;
    vld_sr_d[0]  = issue;
    last_sr_d[0] = issue && issue_last;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end

    push        = vld_sr_q[RD_LAT-1];
    fifo_nempty = (fifo_cnt_q != '0);
    pop         = fifo_nempty && bus.i_ready;
    // Only the very last entry can end the pass; in loop mode earlier passes' last bits may queue.
    drain_end   = (state_q == StDrain) && pop && fifo_last_q[rd_ptr_q] &&
                  (fifo_cnt_q == CntW'(1)) && (inflight == 0);
    done_d      = start_zero || drain_end;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_acc) state_d = (rd_cnt_d == '0) ? StDrain : StRun;
      StRun:   if (rd_cnt_d == '0) state_d = StDrain;
      StDrain: if (drain_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef BIT_READER_LOOP_EN
  // Stop request is held until the reader returns to idle.
  always_comb begin
    stop_d = (state_d == StIdle) ? 1'b0 : (stop_q || bus.i_stop);
  end

  // Stop request register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM outputs: BRAM port-B controls, stream from the FIFO head, status.
  always_comb begin
    bus.o_busy    = (state_q != StIdle);
    bus.o_en_rd   = issue;
    bus.o_addr_rd = issue_addr;
    bus.o_valid   = fifo_nempty;
    bus.o_bit     = fifo_nempty && fifo_bit_q[rd_ptr_q];
    bus.o_last    = fifo_nempty && fifo_last_q[rd_ptr_q];
    bus.o_done    = done_q;
  end

  // Pass bookkeeping and read-latency tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      base_q    <= base_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
      done_q    <= done_d;
    end
  end

  // Output credit FIFO; credits guarantee no push ever lands on a full FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_D; i++) begin
        fifo_bit_q[i]  <= 1'b0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_bit_q[wr_ptr_q]  <= bus.i_rd_bit;
        fifo_last_q[wr_ptr_q] <= last_sr_q[RD_LAT-1];
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_bit_reader.sv
// Bench for bram_bit_reader: port-B memory model with RD_LAT=1, scoreboard queue of expected
// stream bits, one task per scenario. Define BIT_READER_LOOP_EN to include the loop scenario.
module tb_bram_bit_reader;
  localparam int unsigned DEPTH_B = 1976;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned FIFO_D  = RD_LAT + 2;

  typedef struct packed { logic b; logic l; } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_bit_reader_if #(.ADDR_W(ADDR_W)) bus ();

  bram_bit_reader #(
    .DEPTH_B(DEPTH_B),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .FIFO_D (FIFO_D)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic              mem [0:4095];
  logic              rd_bit_q;
  int unsigned       issued = 0;
  int unsigned       xfers = 0;
  int unsigned       credit_viol = 0;
  logic [ADDR_W-1:0] addr_log [$];
  exp_t              exp_q [$];
  int                checks = 0;
  int                errors = 0;
  logic [7:0]        pattern [4] = '{8'hCF, 8'h80, 8'hAA, 8'h31};

  assign bus.i_rd_bit = rd_bit_q;

  // Port-B memory model with one-cycle read latency; also tracks outstanding credits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued   <= 0;
      xfers    <= 0;
      rd_bit_q <= 1'b0;
    end else begin
      if (bus.o_en_rd) begin
        if (issued - xfers >= FIFO_D) credit_viol <= credit_viol + 1;
        issued   <= issued + 1;
        rd_bit_q <= mem[bus.o_addr_rd];
        addr_log.push_back(bus.o_addr_rd);
      end
      if (bus.o_valid && bus.i_ready) xfers <= xfers + 1;
    end
  end

  task automatic preload_main();
    for (int i = 0; i < 4096; i++) mem[i] = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = pattern[i/8][7 - (i % 8)];
  endtask

  // Expected stream: first n bits of CF80AA31, last flag on bit n.
  task automatic push_main(input int n);
    logic [31:0] w;
    w = 32'hCF80AA31;
    for (int i = 0; i < n; i++) exp_q.push_back('{b: w[31-i], l: 1'(i == n - 1)});
  endtask

  task automatic start_pass(input int base, input int len);
    addr_log.delete();
    bus.i_base   = ADDR_W'(base);
    bus.i_length = ADDR_W'(len);
    bus.i_start  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_valid, bus.o_bit, bus.o_last, bus.o_busy, bus.o_done, bus.o_en_rd} !== 6'b0 ||
        bus.o_addr_rd !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v/b/l/busy/done/en=%b%b%b%b%b%b addr=%0d, expected all 0",
               bus.o_valid, bus.o_bit, bus.o_last, bus.o_busy, bus.o_done, bus.o_en_rd,
               bus.o_addr_rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b valid=%b, expected 0 0", bus.o_busy, bus.o_valid);
    end
  endtask

  task automatic test_basic();
    int first_v, last_k, done_k, got;
    exp_t e;
    preload_main();
    exp_q.delete();
    push_main(32);
    bus.i_ready = 1'b1;
    start_pass(0, 32);
    first_v = -1; last_k = -1; done_k = -1; got = 0;
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_valid && first_v < 0) first_v = k;
      if (bus.o_done) begin
        done_k = k;
        checks++;
        if (bus.o_busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_busy_at_done: got %b, expected 0", bus.o_busy);
        end
      end
      if (bus.o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL basic_extra_bit: got an unexpected bit %b, expected none", bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL basic_bit%0d: got bit=%b last=%b, expected bit=%b last=%b",
                     got, bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
        if (bus.o_last) last_k = k;
      end
    end
    checks++;
    if (first_v != 2) begin
      errors++;
      $display("FAIL basic_first_valid: got cycle %0d, expected 2", first_v);
    end
    checks++;
    if (done_k < 0 || done_k != last_k + 1) begin
      errors++;
      $display("FAIL basic_done_timing: got done at %0d last at %0d, expected last+1", done_k,
               last_k);
    end
    checks++;
    if (got != 32 || last_k - first_v != 31) begin
      errors++;
      $display("FAIL basic_throughput: got %0d bits over %0d cycles, expected 32 over 32", got,
               last_k - first_v + 1);
    end
  endtask

  task automatic test_backpressure();
    int got;
    logic done_seen, r, prev_stall, prev_b, prev_l;
    exp_t e;
    exp_q.delete();
    push_main(32);
    bus.i_ready = 1'b0;
    start_pass(0, 32);
    got = 0; done_seen = 1'b0; prev_stall = 1'b0; prev_b = 1'b0; prev_l = 1'b0;
    for (int k = 1; k <= 800 && !done_seen; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (prev_stall) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_bit !== prev_b || bus.o_last !== prev_l) begin
          errors++;
          $display("FAIL bp_stall_hold: got v=%b b=%b l=%b, expected v=1 b=%b l=%b",
                   bus.o_valid, bus.o_bit, bus.o_last, prev_b, prev_l);
        end
      end
      if (bus.o_done) done_seen = 1'b1;
      r = ($urandom_range(0, 1) == 1);
      bus.i_ready = r;
      if (bus.o_valid && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_bit: got an unexpected bit %b, expected none", bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL bp_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", got,
                     bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
      end
      prev_stall = bus.o_valid && !r;
      prev_b = bus.o_bit;
      prev_l = bus.o_last;
    end
    bus.i_ready = 1'b1;
    checks++;
    if (!done_seen || got != 32) begin
      errors++;
      $display("FAIL bp_complete: got done=%b bits=%0d, expected done=1 bits=32", done_seen, got);
    end
    checks++;
    if (credit_viol != 0) begin
      errors++;
      $display("FAIL bp_credit: got %0d over-credit issues, expected 0", credit_viol);
    end
  endtask

  task automatic test_wrap();
    int got;
    logic done_seen;
    logic [7:0] w;
    logic [3:0] hi;
    exp_t e;
    preload_main();
    hi = 4'hA;
    for (int i = 0; i < 4; i++) mem[1972 + i] = hi[3-i];
    w = 8'hAC;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('{b: w[7-i], l: 1'(i == 7)});
    bus.i_ready = 1'b1;
    start_pass(1972, 8);
    got = 0; done_seen = 1'b0;
    for (int k = 1; k <= 100 && !done_seen; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done) done_seen = 1'b1;
      if (bus.o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra_bit: got an unexpected bit %b, expected none", bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL wrap_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", got,
                     bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
      end
    end
    checks++;
    if (!done_seen || addr_log.size() != 8) begin
      errors++;
      $display("FAIL wrap_reads: got done=%b reads=%0d, expected done=1 reads=8", done_seen,
               addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (addr_log[i] !== ADDR_W'((1972 + i) % DEPTH_B)) begin
          errors++;
          $display("FAIL wrap_addr%0d: got %0d, expected %0d", i, addr_log[i],
                   (1972 + i) % DEPTH_B);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int unsigned snap;
    snap = issued;
    addr_log.delete();
    bus.i_base   = ADDR_W'(5);
    bus.i_length = '0;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || issued != snap) begin
      errors++;
      $display("FAIL zero_len_done: got done=%b busy=%b reads=%0d, expected 1 0 0", bus.o_done,
               bus.o_busy, issued - snap);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0 || issued != snap) begin
      errors++;
      $display("FAIL zero_len_pulse: got done=%b reads=%0d, expected 0 0", bus.o_done,
               issued - snap);
    end
  endtask

  task automatic test_start_ignored();
    int got, dones;
    logic done_seen;
    exp_t e;
    preload_main();
    exp_q.delete();
    push_main(32);
    bus.i_ready = 1'b1;
    start_pass(0, 32);
    got = 0; dones = 0; done_seen = 1'b0;
    for (int k = 1; k <= 200 && !done_seen; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (k == 5) begin
        bus.i_base   = ADDR_W'(100);
        bus.i_length = ADDR_W'(5);
        bus.i_start  = 1'b1;
      end
      if (bus.o_done) begin
        done_seen = 1'b1;
        dones++;
      end
      if (bus.o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ign_extra_bit: got an unexpected bit %b, expected none", bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL ign_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", got,
                     bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_valid) dones += 100;
    end
    checks++;
    if (dones != 1 || got != 32) begin
      errors++;
      $display("FAIL ign_pass: got dones=%0d bits=%0d, expected dones=1 bits=32", dones, got);
    end
    checks++;
    if (addr_log.size() != 32 || addr_log[31] !== ADDR_W'(31)) begin
      errors++;
      $display("FAIL ign_reads: got %0d reads, expected 32 reads ending at 31", addr_log.size());
    end
  endtask

  task automatic test_reset_midpass();
    int got;
    logic done_seen;
    exp_t e;
    preload_main();
    exp_q.delete();
    push_main(32);
    bus.i_ready = 1'b1;
    start_pass(0, 32);
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (got == 10) break;
      if (bus.o_valid) begin
        void'(exp_q.pop_front());
        got++;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_bit, bus.o_last, bus.o_busy, bus.o_done, bus.o_en_rd} !== 6'b0 ||
        bus.o_addr_rd !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got v/b/l/busy/done/en=%b%b%b%b%b%b addr=%0d, expected 0",
               bus.o_valid, bus.o_bit, bus.o_last, bus.o_busy, bus.o_done, bus.o_en_rd,
               bus.o_addr_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    push_main(4);
    start_pass(0, 4);
    got = 0; done_seen = 1'b0;
    for (int k = 1; k <= 100 && !done_seen; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done) done_seen = 1'b1;
      if (bus.o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL midreset_extra_bit: got an unexpected bit %b, expected none",
                   bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL midreset_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", got,
                     bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
      end
    end
    checks++;
    if (!done_seen || got != 4) begin
      errors++;
      $display("FAIL midreset_restart: got done=%b bits=%0d, expected done=1 bits=4", done_seen,
               got);
    end
  endtask

`ifdef BIT_READER_LOOP_EN
  task automatic test_loop();
    int got, lasts, dones, gaps;
    logic started;
    logic [7:0] w;
    exp_t e;
    w = 8'hF3;
    for (int i = 0; i < 8; i++) mem[i] = w[7-i];
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back('{b: w[7 - (i % 8)], l: 1'((i % 8) == 7)});
    bus.i_stop  = 1'b0;
    bus.i_ready = 1'b1;
    start_pass(0, 8);
    got = 0; lasts = 0; dones = 0; gaps = 0; started = 1'b0;
    for (int k = 1; k <= 200 && dones == 0; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done) dones++;
      if (started && got < 24 && !bus.o_valid) gaps++;
      if (bus.o_valid) begin
        started = 1'b1;
        if (bus.o_last) lasts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL loop_extra_bit: got an unexpected bit %b, expected none", bus.o_bit);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_bit !== e.b || bus.o_last !== e.l) begin
            errors++;
            $display("FAIL loop_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", got,
                     bus.o_bit, bus.o_last, e.b, e.l);
          end
        end
        got++;
        if (got == 20) bus.i_stop = 1'b1;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.o_done) dones++;
      if (bus.o_valid) got++;
    end
    checks++;
    if (got != 24 || lasts != 3 || dones != 1 || gaps != 0) begin
      errors++;
      $display("FAIL loop_passes: got bits=%0d lasts=%0d dones=%0d gaps=%0d, expected 24 3 1 0",
               got, lasts, dones, gaps);
    end
    preload_main();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start  = 1'b0;
    bus.i_base   = '0;
    bus.i_length = '0;
    bus.i_ready  = 1'b0;
`ifdef BIT_READER_LOOP_EN
    bus.i_stop   = 1'b1;
`endif
    preload_main();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_start_ignored();
    test_reset_midpass();
`ifdef BIT_READER_LOOP_EN
    test_loop();
`endif
    checks++;
    if (credit_viol != 0) begin
      errors++;
      $display("FAIL credit_total: got %0d over-credit issues, expected 0", credit_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
